// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter and its
// return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2,
    PC_MRET   = 2'd3
  } pc_sel_t;

  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  // Bit 1 set in a redirect target means it is not on a 4-byte boundary
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h0000_0002;

  function automatic logic is_misaligned(input logic [31:0] addr_low);
    return |(addr_low & INSTR_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_ras.sv
// Return-address stack: circular buffer whose pointer names the next free
// slot, with a count that saturates at RAS_DEPTH so the oldest entry is lost.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr;
  logic            wr_en;

  // Pop is applied first so a simultaneous push replaces the popped top
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (push_i) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_d;
      ptr_d  = ptr_d + 1'b1;
      if (cnt_d != FULL_COUNT) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_q - 1'b1];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: next-PC selection, trap entry/return through
// the saved EPC, misaligned-redirect trapping and a return-address stack.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_en,
  input  logic            branch_decision,
  input  logic            pc_immediate_jump,
  input  logic [XLEN-1:0] generated_immediate,
  input  logic [XLEN-1:0] pc_write_value,
  input  logic            auipc_in,
  input  logic            call_in,
  input  logic            ret_in,
  input  logic            trap_in,
  input  logic            mret_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_add_4,
  output logic [XLEN-1:0] epc_out,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            misaligned_out
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] seq_pc, rel_target, abs_sum, target;
  logic            target_mis;
  logic            branch_trap;
  pc_sel_t         sel;

  assign seq_pc     = pc_q + XLEN'(4);
  assign rel_target = pc_q + generated_immediate;
  assign abs_sum    = pc_write_value + generated_immediate;
  assign target     = pc_immediate_jump ? {abs_sum[XLEN-1:1], 1'b0} : rel_target;
  assign target_mis = is_misaligned(32'(target[1:0]));

  assign pc_add_4 = auipc_in ? target : seq_pc;

  // A misaligned taken redirect is folded into the trap path
  always_comb begin
    sel         = PC_SEQ;
    branch_trap = 1'b0;
    if (trap_in) begin
      sel = PC_TRAP;
    end else if (mret_in) begin
      sel = PC_MRET;
    end else if (branch_decision) begin
      if (target_mis) begin
        sel         = PC_TRAP;
        branch_trap = 1'b1;
      end else begin
        sel = PC_BRANCH;
      end
    end
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    mis_d = in_en && branch_trap;
    if (in_en) begin
      case (sel)
        PC_TRAP: begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end
        PC_MRET:   pc_d = epc_q;
        PC_BRANCH: pc_d = target;
        default:   pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push_i      (in_en && (sel == PC_BRANCH) && call_in),
    .pop_i       (in_en && (sel == PC_BRANCH) && ret_in),
    .push_data_i (seq_pc),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign pc_out         = pc_q;
  assign epc_out        = epc_q;
  assign misaligned_out = mis_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter unit for the fetch stage of the rv32 core. It extends the basic PC register with configurable width and reset vector, trap entry and return through a saved exception PC, and detection of misaligned jump targets. It also keeps a return-address stack (RAS) that exposes predicted return targets. It sits between branch resolution/decode and instruction-memory addressing.

## Interface
- `XLEN`, default 32: PC and datapath width.
- `RESET_VECTOR`, default 0: PC value loaded on reset.
- `TRAP_VECTOR`, default 32'h100: PC value loaded on trap entry.
- `RAS_DEPTH`, default 4: RAS entries; power of two, ≥2.
- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_en` input 1: PC/RAS/EPC update enable; 0 = stall.
- `branch_decision` input 1: take redirect this cycle.
- `pc_immediate_jump` input 1: redirect base is `pc_write_value` (JALR) instead of current PC.
- `generated_immediate` input XLEN: offset.
- `pc_write_value` input XLEN: absolute base (rs1).
- `auipc_in` input 1: select `pc_add_4` = PC + immediate.
- `call_in` input 1: redirect is a call; push return address.
- `ret_in` input 1: redirect is a return; pop RAS.
- `trap_in` input 1: enter trap.
- `mret_in` input 1: return from trap.
- `pc_out` output XLEN: current PC (registered).
- `pc_add_4` output XLEN: `auipc_in` ? redirect target : PC+4 (combinational).
- `epc_out` output XLEN: saved exception PC.
- `ras_top` output XLEN: top RAS entry (predicted return target).
- `ras_empty` output 1: RAS holds no entries.
- `misaligned_out` output 1: one-cycle pulse after a misaligned redirect trapped.

## Operation
- Redirect target:
  - Relative (`pc_immediate_jump`=0): PC + imm.
  - Absolute (`pc_immediate_jump`=1): (`pc_write_value` + imm) with bit 0 cleared.
  - All adds are modulo 2^XLEN.
- Misaligned: a taken redirect whose target has bit 1 set.
- Next-PC priority, applied only when `in_en`=1:
  1. `trap_in`: PC ← `TRAP_VECTOR`, EPC ← PC.
  2. `mret_in`: PC ← EPC.
  3. `branch_decision` with misaligned target: PC ← `TRAP_VECTOR`, EPC ← PC, `misaligned_out` pulses.
  4. `branch_decision`: PC ← target.
  5. Otherwise: PC ← PC+4.
- `in_en`=0: PC, EPC and RAS hold; `misaligned_out` deasserts. `pc_add_4` still reflects current inputs.
- RAS updates only when a redirect of priority 4 is taken.
  - `call_in` pushes PC+4.
  - `ret_in` pops.
  - Both asserted: pop then push, so the top is replaced and the count is unchanged; if the RAS was empty the count becomes 1.
  - Push when full: circular overwrite of the oldest entry; the count saturates at `RAS_DEPTH`.
  - Pop when empty: no change; `ras_top` is don't-care while `ras_empty`=1.
- Traps, `mret` and misaligned redirects never touch the RAS.
- Reset values:
  - `pc_out` = `RESET_VECTOR`
  - `epc_out` = 0
  - `misaligned_out` = 0
  - RAS count = 0, pointer = 0, `ras_empty` = 1
  - RAS entries are not reset.

## Timing
- `pc_out`, `epc_out`, `misaligned_out`, `ras_top` and `ras_empty` are registered or decoded from state; each change is visible after the updating rising edge.
- `pc_add_4` is combinational from the current PC and the inputs, with zero latency.
- A redirect takes effect in one cycle; there are no bubbles inside this block.
- `misaligned_out` is high for exactly the one cycle following the trapping edge.
- `reset` asserted mid-operation forces reset values immediately (asynchronously), regardless of `clock` or `in_en`.

## Structure
- Shared package `pc_pkg` holds:
  - enum `pc_sel_t` {`PC_SEQ`, `PC_BRANCH`, `PC_TRAP`, `PC_MRET`}
  - default `TRAP_VECTOR` constant
  - instruction-alignment mask constant
- Sub-module `pc_ras` implements the return-address stack:
  - parameters `XLEN`, `RAS_DEPTH`
  - circular buffer with a `$clog2(RAS_DEPTH)`-bit pointer and a saturating count
- Top level holds the next-PC mux, EPC and misalignment logic.

## Test plan
All scenarios use defaults (`RESET_VECTOR`=0, `TRAP_VECTOR`=0x100, `RAS_DEPTH`=4).
- Reset, then 2 clocks with `in_en`=1 → `pc_out` goes 0, 4, 8. Hold `in_en`=0 for 3 clocks → `pc_out` stays 8.
- Relative branch at PC=8 with imm=0xFFFFFFF0 → PC=0xFFFFFFF8. Absolute jump with base 0x201, imm 0 → PC=0x200 (bit 0 cleared). Relative branch from PC=0x200 with imm=6 → PC=0x100, `epc_out`=0x200, `misaligned_out`=1 for one cycle.
- `trap_in` at PC=0x40 → PC=0x100, `epc_out`=0x40. Next cycle `mret_in` → PC=0x40. `trap_in` and `mret_in` together → trap wins.
- 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_top`=0x54. Then 4 returns → top shows 0x44, 0x34, 0x24, then `ras_empty`=1 (0x14 was overwritten). A 5th return → no change.
- `call_in` and `ret_in` together from PC=0x80 with one entry 0x14 on the stack → `ras_top`=0x84, count stays 1.
- `auipc_in`=1, imm=0x1000, PC=0x40 → `pc_add_4`=0x1040. Assert `reset` between clock edges → `pc_out`=0 and `ras_empty`=1 immediately.
